// File: rtl/ch_announce_tx_if.sv
// Transmit link for the CH-advertisement stream.
// Handshake: a word transfers on every rising clk edge where tx_valid and
// tx_ready are both high. While tx_valid is high and tx_ready is low, the
// sender holds tx_data and tx_last stable. tx_data is zero whenever tx_valid
// is low. tx_last marks the final word of a packet.
interface ch_announce_tx_if #(
    parameter int WORD_WIDTH = 16
);
    logic [WORD_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_last;
    logic                  tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        output tx_last,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        input  tx_last,
        output tx_ready
    );
endinterface

// File: rtl/ch_announce_tx.sv
// Cluster-head announcement transmitter.
// On en_CHA the node's ID, hop count, Q-value and CH limit are captured.
// The block then waits a seeded backoff and streams a five-word
// advertisement (header, ID, hops, Q, limit) over the tx link.
// HB_reset abandons any packet in flight. All outputs come straight from
// flops, so there is no path from tx_ready or en_CHA to an output.
module ch_announce_tx #(
    parameter int                    WORD_WIDTH    = 16,
    parameter int                    BACKOFF_WIDTH = 8,
    parameter logic [WORD_WIDTH-1:0] MSG_TYPE_CH   = 16'h0003
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     en_CHA,
    input  logic                     HB_reset,
    input  logic [WORD_WIDTH-1:0]    node_ID,
    input  logic [WORD_WIDTH-1:0]    node_Hops,
    input  logic [WORD_WIDTH-1:0]    node_QValue,
    input  logic [WORD_WIDTH-1:0]    HB_CHlimit,
    input  logic [BACKOFF_WIDTH-1:0] backoff_seed,
    ch_announce_tx_if.master         tx,
    output logic                     busy,
    output logic                     done,
    output logic [1:0]               dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BACKOFF = 2'd1,
        S_SEND    = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t                   state;
    logic [BACKOFF_WIDTH-1:0] cnt;
    logic [2:0]               idx;
    logic [2:0]               idx_next;

    // Fields captured at the start edge; later input changes do not leak in.
    logic [WORD_WIDTH-1:0]    id_q;
    logic [WORD_WIDTH-1:0]    hops_q;
    logic [WORD_WIDTH-1:0]    qval_q;
    logic [WORD_WIDTH-1:0]    limit_q;

    // Registered copies of the link outputs.
    logic [WORD_WIDTH-1:0]    data_r;
    logic                     valid_r;
    logic                     last_r;
    logic                     busy_r;
    logic                     done_r;

    logic [WORD_WIDTH-1:0]    pkt [5];

    assign idx_next = idx + 3'd1;

    // Packet layout, indexed by word position.
    always_comb begin
        pkt[0] = MSG_TYPE_CH;
        pkt[1] = id_q;
        pkt[2] = hops_q;
        pkt[3] = qval_q;
        pkt[4] = limit_q;
    end

    // Main FSM; outputs are computed alongside each transition so they are
    // valid in the same cycle the new state is.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            idx     <= '0;
            id_q    <= '0;
            hops_q  <= '0;
            qval_q  <= '0;
            limit_q <= '0;
            data_r  <= '0;
            valid_r <= 1'b0;
            last_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (HB_reset) begin
                // Abort wins over start and over a pending handshake.
                state   <= S_IDLE;
                cnt     <= '0;
                idx     <= '0;
                data_r  <= '0;
                valid_r <= 1'b0;
                last_r  <= 1'b0;
                busy_r  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (en_CHA) begin
                            id_q    <= node_ID;
                            hops_q  <= node_Hops;
                            qval_q  <= node_QValue;
                            limit_q <= HB_CHlimit;
                            cnt     <= backoff_seed;
                            busy_r  <= 1'b1;
                            state   <= S_BACKOFF;
                        end
                    end
                    S_BACKOFF: begin
                        // A zero seed still spends one cycle here.
                        if (cnt == '0) begin
                            idx     <= '0;
                            data_r  <= MSG_TYPE_CH;
                            valid_r <= 1'b1;
                            last_r  <= 1'b0;
                            state   <= S_SEND;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    S_SEND: begin
                        if (valid_r && tx.tx_ready) begin
                            if (idx < 3'd4) begin
                                idx    <= idx_next;
                                data_r <= pkt[idx_next];
                                last_r <= (idx_next == 3'd4);
                            end else begin
                                idx     <= '0;
                                data_r  <= '0;
                                valid_r <= 1'b0;
                                last_r  <= 1'b0;
                                done_r  <= 1'b1;
                                state   <= S_DONE;
                            end
                        end
                    end
                    S_DONE: begin
                        busy_r <= 1'b0;
                        state  <= S_IDLE;
                    end
                    default: begin
                        state   <= S_IDLE;
                        data_r  <= '0;
                        valid_r <= 1'b0;
                        last_r  <= 1'b0;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign tx.tx_data  = data_r;
    assign tx.tx_valid = valid_r;
    assign tx.tx_last  = last_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign dbg_state   = state;

endmodule
